// File: rtl/aes192_inv_key_sched_pkg.sv
// Shared constants, FSM encoding and GF(2^8) helpers for the AES-192 reverse key schedule.
// The S-box is computed arithmetically: multiplicative inverse followed by the affine map.
package aes192_inv_key_sched_pkg;

    localparam int         AES192_NR = 12;
    localparam int         KEY_W     = 192;
    localparam int         RK_W      = 128;
    localparam int         WORD_W    = 32;
    localparam logic [7:0] RCON_INIT = 8'h80;
    localparam logic [5:0] J_INIT    = 6'd46;
    localparam logic [3:0] R_INIT    = 4'(AES192_NR);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EMIT = 2'd1,
        STEP = 2'd2,
        SUB  = 2'd3
    } state_t;

    function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p;
        logic [7:0] aa;
        logic [7:0] bb;
        p  = 8'h00;
        aa = a;
        bb = b;
        for (int k = 0; k < 8; k++) begin
            if (bb[0]) begin
                p = p ^ aa;
            end
            aa = {aa[6:0], 1'b0} ^ (aa[7] ? 8'h1b : 8'h00);
            bb = {1'b0, bb[7:1]};
        end
        return p;
    endfunction

    // a^254 is the field inverse (and maps 0 to 0, as the S-box requires)
    function automatic logic [7:0] sbox(input logic [7:0] a);
        logic [7:0] p;
        logic [7:0] inv;
        p   = a;
        inv = 8'h01;
        for (int k = 1; k < 8; k++) begin
            p   = gf_mul(p, p);
            inv = gf_mul(inv, p);
        end
        return inv ^ {inv[6:0], inv[7]} ^ {inv[5:0], inv[7:6]} ^
               {inv[4:0], inv[7:5]} ^ {inv[3:0], inv[7:4]} ^ 8'h63;
    endfunction

    function automatic logic [WORD_W-1:0] rot_word(input logic [WORD_W-1:0] w);
        return {w[23:0], w[31:24]};
    endfunction

endpackage

// File: rtl/aes192_inv_key_sched_s4.sv
// Registered 4-byte S-box: result of din appears on dout one clock later.
module aes192_inv_key_sched_s4
    import aes192_inv_key_sched_pkg::*;
(
    input  logic              clk,
    input  logic              rst,
    input  logic [WORD_W-1:0] din,
    output logic [WORD_W-1:0] dout
);

    logic [WORD_W-1:0] sub_d;
    logic [WORD_W-1:0] dout_q;

    generate
        for (genvar gi = 0; gi < 4; gi++) begin : g_sbox
            assign sub_d[8*gi +: 8] = sbox(din[8*gi +: 8]);
        end
    endgenerate

    always_ff @(posedge clk) begin
        if (rst) begin
            dout_q <= '0;
        end else begin
            dout_q <= sub_d;
        end
    end

    assign dout = dout_q;

endmodule

// File: rtl/aes192_inv_key_sched.sv
// AES-192 key schedule run backwards from w46..w51, emitting RK12..RK0 over valid/ready.
// A six-word window slides down one word per step; S-box steps share one registered S4.
module aes192_inv_key_sched
    import aes192_inv_key_sched_pkg::*;
(
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [KEY_W-1:0] key_in,
    output logic             busy,
    output logic             rk_valid,
    input  logic             rk_ready,
    output logic [RK_W-1:0]  rk_out,
    output logic [3:0]       rk_idx,
    output logic             done
);

    state_t                 state_q, state_d;
    logic [5:0][WORD_W-1:0] win_q, win_d, win_load;
    logic [5:0]             j_q, j_d;
    logic [3:0]             r_q, r_d;
    logic [7:0]             rcon_q, rcon_d;
    logic                   sub_wait_q, sub_wait_d;
    logic                   done_q, done_d;

    logic [WORD_W-1:0]      s4_in, s4_out, step_word, sub_word;
    logic [5:0]             key_base;
    logic [1:0]             offset;
    logic                   covered, sub_step;

    // window slot 0 holds the lowest-numbered word, w46 on load
    generate
        for (genvar gi = 0; gi < 6; gi++) begin : g_load
            assign win_load[gi] = key_in[KEY_W-1-WORD_W*gi -: WORD_W];
        end
    endgenerate

    assign key_base  = {r_q, 2'b00};
    assign offset    = 2'(key_base - j_q);
    assign covered   = (j_q <= key_base);
    assign sub_step  = ((j_q % 6'd6) == 6'd1);
    assign s4_in     = rot_word(win_q[4]);
    assign step_word = win_q[5] ^ win_q[4];
    assign sub_word  = win_q[5] ^ (s4_out ^ {rcon_q, 24'h000000});

    aes192_inv_key_sched_s4 u_s4 (
        .clk  (clk),
        .rst  (rst),
        .din  (s4_in),
        .dout (s4_out)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= IDLE;
            win_q      <= '0;
            j_q        <= '0;
            r_q        <= '0;
            rcon_q     <= '0;
            sub_wait_q <= 1'b0;
            done_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            win_q      <= win_d;
            j_q        <= j_d;
            r_q        <= r_d;
            rcon_q     <= rcon_d;
            sub_wait_q <= sub_wait_d;
            done_q     <= done_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        win_d      = win_q;
        j_d        = j_q;
        r_d        = r_q;
        rcon_d     = rcon_q;
        sub_wait_d = sub_wait_q;
        done_d     = 1'b0;
        case (state_q)
            IDLE: begin
                if (start) begin
                    state_d = EMIT;
                    win_d   = win_load;
                    j_d     = J_INIT;
                    r_d     = R_INIT;
                    rcon_d  = RCON_INIT;
                end
            end
            EMIT: begin
                if (covered) begin
                    if (rk_ready) begin
                        if (r_q == 4'd0) begin
                            state_d = IDLE;
                            done_d  = 1'b1;
                        end else begin
                            r_d = r_q - 4'd1;
                        end
                    end
                end else if (sub_step) begin
                    state_d    = SUB;
                    sub_wait_d = 1'b1;
                end else begin
                    state_d = STEP;
                end
            end
            STEP: begin
                win_d   = {win_q[4:0], step_word};
                j_d     = j_q - 6'd1;
                state_d = EMIT;
            end
            SUB: begin
                // first cycle only lets the registered S4 result settle
                if (sub_wait_q) begin
                    sub_wait_d = 1'b0;
                end else begin
                    win_d   = {win_q[4:0], sub_word};
                    j_d     = j_q - 6'd1;
                    rcon_d  = {1'b0, rcon_q[7:1]};
                    state_d = EMIT;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        busy     = (state_q != IDLE);
        rk_valid = (state_q == EMIT) && covered;
        rk_idx   = r_q;
        done     = done_q;
        case (offset)
            2'd0:    rk_out = {win_q[0], win_q[1], win_q[2], win_q[3]};
            2'd1:    rk_out = {win_q[1], win_q[2], win_q[3], win_q[4]};
            default: rk_out = {win_q[2], win_q[3], win_q[4], win_q[5]};
        endcase
    end

endmodule

// File: tb/tb_aes192_inv_key_sched.sv
// Bench for the reverse AES-192 key schedule: forward-expands each key in software and
// scoreboards the 13 emitted round keys, with stalls, ignored starts and mid-run reset.
module tb_aes192_inv_key_sched;

    localparam int N_STEPS = 46;
    localparam int N_SUB   = 8;
    localparam int N_KEYS  = 13;
    localparam int EXP_LAT = N_STEPS + N_SUB + (N_KEYS + N_STEPS) + 1;

    logic         clk;
    logic         rst;
    logic         start;
    logic [191:0] key_in;
    logic         busy;
    logic         rk_valid;
    logic         rk_ready;
    logic [127:0] rk_out;
    logic [3:0]   rk_idx;
    logic         done;

    typedef struct {
        logic [3:0]   idx;
        logic [127:0] key;
    } exp_t;

    exp_t        sb[$];
    int          checks   = 0;
    int          errors   = 0;
    int          done_cnt = 0;
    logic [7:0]  sbt [256];
    logic [31:0] wm  [52];
    bit          bp_mode     = 1'b0;
    logic        ready_level = 1'b1;

    aes192_inv_key_sched dut (
        .clk      (clk),
        .rst      (rst),
        .start    (start),
        .key_in   (key_in),
        .busy     (busy),
        .rk_valid (rk_valid),
        .rk_ready (rk_ready),
        .rk_out   (rk_out),
        .rk_idx   (rk_idx),
        .done     (done)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // S-box table from the generator-walk construction (independent of any field inversion)
    task automatic build_sbox();
        logic [7:0] p;
        logic [7:0] q;
        logic [7:0] x;
        p = 8'h01;
        q = 8'h01;
        do begin
            p = p ^ {p[6:0], 1'b0} ^ (p[7] ? 8'h1b : 8'h00);
            q = q ^ {q[6:0], 1'b0};
            q = q ^ {q[5:0], 2'b00};
            q = q ^ {q[3:0], 4'b0000};
            if (q[7]) q = q ^ 8'h09;
            x = q ^ {q[6:0], q[7]} ^ {q[5:0], q[7:6]} ^ {q[4:0], q[7:5]} ^ {q[3:0], q[7:4]};
            sbt[p] = x ^ 8'h63;
        end while (p != 8'h01);
        sbt[0] = 8'h63;
    endtask

    task automatic expand(input logic [191:0] key);
        logic [31:0] t;
        logic [7:0]  rc;
        rc = 8'h01;
        for (int i = 0; i < 6; i++) wm[i] = key[191-32*i -: 32];
        for (int i = 6; i < 52; i++) begin
            t = wm[i-1];
            if (i % 6 == 0) begin
                t  = {t[23:0], t[31:24]};
                t  = {sbt[t[31:24]], sbt[t[23:16]], sbt[t[15:8]], sbt[t[7:0]]} ^ {rc, 24'h000000};
                rc = {rc[6:0], 1'b0} ^ (rc[7] ? 8'h1b : 8'h00);
            end
            wm[i] = wm[i-6] ^ t;
        end
    endtask

    function automatic logic [127:0] rkey(input int r);
        return {wm[4*r], wm[4*r+1], wm[4*r+2], wm[4*r+3]};
    endfunction

    function automatic logic [191:0] tail_words();
        return {wm[46], wm[47], wm[48], wm[49], wm[50], wm[51]};
    endfunction

    function automatic logic [191:0] rand_key();
        return {$urandom(), $urandom(), $urandom(), $urandom(), $urandom(), $urandom()};
    endfunction

    task automatic push_expected(input bit fips);
        exp_t e;
        for (int r = 12; r >= 0; r--) begin
            e.idx = 4'(r);
            e.key = rkey(r);
            if (fips && r == 12) e.key = 128'he98ba06f448c773c8ecc720401002202;
            if (fips && r == 0)  e.key = 128'h8e73b0f7da0e6452c810f32b809079e5;
            sb.push_back(e);
        end
    endtask

    task automatic run_key(input logic [191:0] key, input bit fips, input bit check_lat,
                           input bit mid_start);
        int cycles;
        bit timed_out;
        expand(key);
        push_expected(fips);
        done_cnt = 0;
        @(posedge clk);
        #1;
        key_in = tail_words();
        start  = 1'b1;
        @(posedge clk);
        #1;
        start     = 1'b0;
        key_in    = rand_key();
        cycles    = 0;
        timed_out = 1'b1;
        for (int c = 0; c < 4000; c++) begin
            @(negedge clk);
            cycles++;
            if (mid_start && cycles == 20) begin
                check("busy_mid", 128'(busy), 128'(1));
                start = 1'b1;
            end
            if (mid_start && cycles == 21) start = 1'b0;
            if (done) begin
                timed_out = 1'b0;
                break;
            end
        end
        check("done_timeout", 128'(timed_out), 128'(0));
        if (check_lat) check("latency", 128'(cycles), 128'(EXP_LAT));
        repeat (2) @(negedge clk);
        check("done_once", 128'(done_cnt), 128'(1));
        check("no_drop", 128'(sb.size()), 128'(0));
        check("idle_busy", 128'(busy), 128'(0));
        sb.delete();
        $display("run key=%h bp=%0d cycles=%0d checks=%0d", key, bp_mode, cycles, checks);
    endtask

    // rk_ready driver
    initial begin
        rk_ready = 1'b0;
        forever begin
            @(posedge clk);
            #1;
            rk_ready = bp_mode ? 1'($urandom_range(0, 1)) : ready_level;
        end
    end

    // monitor: handshakes against the scoreboard, stability while stalled, done pulses
    initial begin
        logic         stall_prev;
        logic [127:0] out_prev;
        logic [3:0]   idx_prev;
        exp_t         e;
        stall_prev = 1'b0;
        out_prev   = '0;
        idx_prev   = '0;
        forever begin
            @(negedge clk);
            if (rst) begin
                stall_prev = 1'b0;
            end else begin
                if (stall_prev) begin
                    check("hold_valid", 128'(rk_valid), 128'(1));
                    check("hold_out", rk_out, out_prev);
                    check("hold_idx", 128'(rk_idx), 128'(idx_prev));
                end
                if (rk_valid && rk_ready) begin
                    check("key_expected", 128'(sb.size() != 0), 128'(1));
                    if (sb.size() != 0) begin
                        e = sb.pop_front();
                        check("rk_idx", 128'(rk_idx), 128'(e.idx));
                        check("rk_out", rk_out, e.key);
                    end
                end
                if (done) done_cnt++;
                stall_prev = rk_valid && !rk_ready;
                out_prev   = rk_out;
                idx_prev   = rk_idx;
            end
        end
    end

    initial begin
        logic [191:0] key;
        bit           found;
        rst    = 1'b1;
        start  = 1'b0;
        key_in = '0;
        build_sbox();
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("rst_busy", 128'(busy), 128'(0));
        check("rst_valid", 128'(rk_valid), 128'(0));
        check("rst_out", rk_out, 128'(0));
        check("rst_idx", 128'(rk_idx), 128'(0));
        check("rst_done", 128'(done), 128'(0));
        @(posedge clk);
        #1;
        rst = 1'b0;

        // FIPS-197 A.2 key, ready tied high, cycle count checked
        bp_mode     = 1'b0;
        ready_level = 1'b1;
        run_key(192'h8e73b0f7da0e6452c810f32b809079e562f8ead2522c6b7b, 1'b1, 1'b1, 1'b0);

        // same key under random backpressure with a start pulse while busy
        bp_mode = 1'b1;
        run_key(192'h8e73b0f7da0e6452c810f32b809079e562f8ead2522c6b7b, 1'b1, 1'b0, 1'b1);

        // replay with a new key right after done
        bp_mode = 1'b0;
        run_key(rand_key(), 1'b0, 1'b1, 1'b0);

        // reset in the S-box wait of the j=25 step (8 cycles after the RK7 handshake)
        key = rand_key();
        expand(key);
        push_expected(1'b0);
        @(posedge clk);
        #1;
        key_in = tail_words();
        start  = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        found = 1'b0;
        for (int c = 0; c < 300; c++) begin
            @(negedge clk);
            if (rk_valid && rk_ready && rk_idx == 4'd7) begin
                found = 1'b1;
                break;
            end
        end
        check("reach_rk7", 128'(found), 128'(1));
        repeat (8) @(posedge clk);
        #1;
        check("sub_busy", 128'(busy), 128'(1));
        check("sub_no_valid", 128'(rk_valid), 128'(0));
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        check("abort_busy", 128'(busy), 128'(0));
        check("abort_valid", 128'(rk_valid), 128'(0));
        check("abort_out", rk_out, 128'(0));
        check("abort_idx", 128'(rk_idx), 128'(0));
        check("abort_done", 128'(done), 128'(0));
        sb.delete();
        repeat (10) @(negedge clk);
        check("abort_stays_idle", 128'(busy), 128'(0));
        check("abort_no_key", 128'(rk_valid), 128'(0));
        $display("reset during SUB j=25 key=%h", key);

        run_key(rand_key(), 1'b0, 1'b1, 1'b0);

        // random keys, alternating tied-high and random rk_ready
        for (int k = 0; k < 150; k++) begin
            bp_mode = (k % 2 == 1);
            run_key(rand_key(), 1'b0, !bp_mode, (k % 10 == 3));
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
